dbus_arbiter: RTL and testbench
===============================

// Module: dbus_arbiter
// PURPOSE
//   Shares the CPU data bus (data memory + peripheral window) between the CPU load/store
//   port (m0) and a second bus master (m1: UART loader / DMA). Sequences ownership with a
//   small FSM and a starvation counter, stalls the CPU while m1 owns the bus, and performs
//   the DM/peripheral address decode for whichever master is granted.
// PARAMETERS
//   DATA_W      32       data width of all wdata/rdata buses
//   ADDR_W      32       address width
//   MAX_WAIT    8        cycles m1 may be blocked by continuous m0 traffic before forced grant
//   MAX_LOCK    16       max consecutive m1 beats under lock before the bus returns to m0
//   PERIPH_TAG  4'b0100  addr[31:28] value selecting the peripheral window
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   reset      in   1       asynchronous, active-high reset
//   m0_req     in   1       CPU access this cycle (MemRd | MemWr)
//   m0_we      in   1       CPU write
//   m0_addr    in   ADDR_W  CPU address (ALU result)
//   m0_wdata   in   DATA_W  CPU store data
//   m0_rdata   out  DATA_W  CPU load data
//   m0_stall   out  1       CPU must hold PC and suppress RegWr/MemWr this cycle
//   m1_req     in   1       m1 access request, held until m1_gnt
//   m1_we      in   1       m1 write
//   m1_lock    in   1       m1 requests to keep ownership for the next beat
//   m1_addr    in   ADDR_W  m1 address
//   m1_wdata   in   DATA_W  m1 write data
//   m1_gnt     out  1       m1 access performed this cycle
//   m1_rdata   out  DATA_W  m1 read data, valid when m1_rvalid
//   m1_rvalid  out  1       m1_gnt & ~m1_we
//   dm_addr/dm_wdata out ADDR_W/DATA_W, dm_rd/dm_wr out 1, dm_rdata in DATA_W   data memory side
//   pr_addr/pr_wdata out ADDR_W/DATA_W, pr_rd/pr_wr out 1, pr_rdata in DATA_W   peripheral side
// BEHAVIOUR
//   - Reset: state=OWN_M0, wait_cnt=0, lock_cnt=0; m1_gnt=0, m0_stall=0, m1_rvalid=0.
//   - States: OWN_M0 (bus driven by m0), OWN_M1 (bus driven by m1). Ownership is registered;
//     decode, strobes and rdata muxing are combinational (zero-latency reads, as single-cycle).
//   - OWN_M0 -> OWN_M1 at edge when m1_req & (~m0_req | wait_cnt==MAX_WAIT-1).
//     wait_cnt increments when m1_req & m0_req in OWN_M0; cleared on entry to OWN_M1 or ~m1_req.
//   - OWN_M1: m1_gnt=m1_req; one beat per cycle; lock_cnt increments per granted beat.
//     Stay if m1_req & m1_lock & lock_cnt<MAX_LOCK-1; else -> OWN_M0 (lock_cnt cleared).
//     After a forced return (lock_cnt limit) m0 owns >=1 cycle even if m1_req stays high.
//     m1_req low in OWN_M1 -> OWN_M0 next edge, no access issued that cycle.
//   - m0_stall = (state==OWN_M1) & m0_req; stalled m0 issues no strobes. m0 is never dropped:
//     a stalled access completes on its first OWN_M0 cycle.
//   - Decode (granted master g): periph = g_addr[31:28]==PERIPH_TAG.
//     dm_wr=g_req&g_we&~periph; pr_wr=g_req&g_we&periph; dm_rd/pr_rd likewise with ~g_we.
//     Addresses/wdata forwarded unmodified to both sides; rdata = periph ? pr_rdata : dm_rdata,
//     routed to granted master only; non-granted rdata driven 0.
//   - Simultaneous m0_req & m1_req with wait_cnt<MAX_WAIT-1: m0 wins, m1 waits.
//   - Reset asserted mid-burst: immediate return to OWN_M0, all strobes 0, no partial write.
//   - wait_cnt/lock_cnt saturate; widths $clog2(MAX_WAIT)/$clog2(MAX_LOCK), never wrap.
// STRUCTURE
//   - Package dbus_pkg: state enum {OWN_M0, OWN_M1}, PERIPH_TAG, DATA_W/ADDR_W defaults.
//   - Sub-module dbus_decoder (combinational): addr/we/req -> dm_*/pr_* strobes + rdata mux.
//   - Top holds FSM, wait_cnt, lock_cnt, master select mux.
// TESTING
//   1. Reset high 3 cycles mid-activity -> m1_gnt=0, m0_stall=0, all strobes 0, state OWN_M0.
//   2. m0 idle, m1 write 0xDEADBEEF @0x00000010 -> m1_gnt next cycle, dm_wr=1, pr_wr=0.
//   3. m0_req continuous, m1_req held -> m1 granted on 9th cycle (MAX_WAIT=8), m0_stall=1 then.
//   4. m1 locked burst 20 beats @0x40000000.. -> pr_wr on 16 beats, 1 OWN_M0 cycle, resume.
//   5. m0 load @0x40000004 while pr_rdata=0x5A -> m0_rdata=0x5A, dm_rd=0, pr_rd=1.
//   6. m0 store stalled by m1 beat -> store issued exactly once, first cycle after m1 release.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared types and defaults for the data-bus arbiter.
// Ownership enum plus the peripheral window tag.
package dbus_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  localparam logic [3:0] PERIPH_TAG = 4'b0100;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } own_e;

endpackage

// File: rtl/dbus_decoder.sv
// Address decode for the granted master:
// DM / peripheral strobes and read-data mux.
module dbus_decoder
  import dbus_pkg::*;
#(
  parameter int         DATA_W = DATA_W_DEF,
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter logic [3:0] TAG    = PERIPH_TAG
) (
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  output logic              dm_rd_o,
  output logic              dm_wr_o,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic [ADDR_W-1:0] pr_addr_o,
  output logic [DATA_W-1:0] pr_wdata_o,
  output logic              pr_rd_o,
  output logic              pr_wr_o,
  input  logic [DATA_W-1:0] pr_rdata_i
);

  logic periph;

  // Top nibble selects the peripheral window.
  always_comb begin
    periph     = (addr_i[ADDR_W-1 -: 4] == TAG);
    dm_addr_o  = addr_i;
    pr_addr_o  = addr_i;
    dm_wdata_o = wdata_i;
    pr_wdata_o = wdata_i;
    dm_wr_o    = req_i & we_i & ~periph;
    pr_wr_o    = req_i & we_i & periph;
    dm_rd_o    = req_i & ~we_i & ~periph;
    pr_rd_o    = req_i & ~we_i & periph;
    rdata_o    = periph ? pr_rdata_i : dm_rdata_i;
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: CPU (m0) vs loader/DMA (m1).
// Registered ownership FSM, starvation and lock counters.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int         DATA_W   = DATA_W_DEF,
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter int         MAX_WAIT = 8,
  parameter int         MAX_LOCK = 16,
  parameter logic [3:0] P_TAG    = PERIPH_TAG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rd,
  output logic              dm_wr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] pr_addr,
  output logic [DATA_W-1:0] pr_wdata,
  output logic              pr_rd,
  output logic              pr_wr,
  input  logic [DATA_W-1:0] pr_rdata
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);

  own_e            state_q;
  logic [WW-1:0]   wait_q;
  logic [LW-1:0]   lock_q;

  logic              own1;
  logic              g_req;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [DATA_W-1:0] g_rdata;

  assign own1 = (state_q == OWN_M1);

  // Ownership FSM; counters saturate at their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OWN_M0;
      wait_q  <= '0;
      lock_q  <= '0;
    end else begin
      unique case (state_q)
        OWN_M0: begin
          lock_q <= '0;
          if (m1_req && (!m0_req || wait_q == WAIT_LAST)) begin
            state_q <= OWN_M1;
            wait_q  <= '0;
          end else if (m1_req && m0_req) begin
            if (wait_q != WAIT_LAST)
              wait_q <= wait_q + WW'(1);
          end else begin
            wait_q <= '0;
          end
        end
        OWN_M1: begin
          wait_q <= '0;
          if (m1_req && m1_lock && lock_q < LOCK_LAST) begin
            lock_q <= lock_q + LW'(1);
          end else begin
            state_q <= OWN_M0;
            lock_q  <= '0;
          end
        end
        default: begin
          state_q <= OWN_M0;
          wait_q  <= '0;
          lock_q  <= '0;
        end
      endcase
    end
  end

  // Select the owning master; reset kills every strobe.
  always_comb begin
    g_req   = 1'b0;
    g_we    = 1'b0;
    g_addr  = m0_addr;
    g_wdata = m0_wdata;
    if (own1) begin
      g_req   = m1_req;
      g_we    = m1_we;
      g_addr  = m1_addr;
      g_wdata = m1_wdata;
    end else begin
      g_req   = m0_req;
      g_we    = m0_we;
    end
    if (reset)
      g_req = 1'b0;
  end

  // Handshake outputs and read-data routing.
  always_comb begin
    m0_stall  = own1 & m0_req;
    m1_gnt    = own1 & m1_req & ~reset;
    m1_rvalid = m1_gnt & ~m1_we;
    m0_rdata  = own1 ? '0 : g_rdata;
    m1_rdata  = own1 ? g_rdata : '0;
  end

  dbus_decoder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TAG    (P_TAG)
  ) u_dec (
    .req_i      (g_req),
    .we_i       (g_we),
    .addr_i     (g_addr),
    .wdata_i    (g_wdata),
    .rdata_o    (g_rdata),
    .dm_addr_o  (dm_addr),
    .dm_wdata_o (dm_wdata),
    .dm_rd_o    (dm_rd),
    .dm_wr_o    (dm_wr),
    .dm_rdata_i (dm_rdata),
    .pr_addr_o  (pr_addr),
    .pr_wdata_o (pr_wdata),
    .pr_rd_o    (pr_rd),
    .pr_wr_o    (pr_wr),
    .pr_rdata_i (pr_rdata)
  );

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: decode table
// plus starvation, lock-burst, reset and stall sequences.
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_stall;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_rd, dm_wr;
  logic [31:0] pr_addr, pr_wdata, pr_rdata;
  logic        pr_rd, pr_wr;

  logic [3:0]  strb;
  assign strb = {dm_rd, dm_wr, pr_rd, pr_wr};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dmr;
    logic [31:0] prr;
    logic [3:0]  e_strb;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[7];

  dbus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_stall  (m0_stall),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_rdata  (dm_rdata),
    .pr_addr   (pr_addr),
    .pr_wdata  (pr_wdata),
    .pr_rd     (pr_rd),
    .pr_wr     (pr_wr),
    .pr_rdata  (pr_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0;
    m1_addr = 0; m1_wdata = 0;
  endtask

  int          run1, gap, beats, phase, bad, st, gcyc;
  logic        g;
  logic [31:0] ea;

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,
              32'h1111_1111, 32'h2222_2222, 4'b1000, 32'h1111_1111};
    vt[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_CAFE,
              32'h1111_1111, 32'h2222_2222, 4'b0100, 32'h1111_1111};
    vt[2] = '{1'b1, 1'b0, 32'h4000_0004, 32'h0,
              32'h0000_0033, 32'h0000_005A, 4'b0010, 32'h0000_005A};
    vt[3] = '{1'b1, 1'b1, 32'h4000_0008, 32'h1234_0000,
              32'h0000_0033, 32'h0000_0066, 4'b0001, 32'h0000_0066};
    vt[4] = '{1'b0, 1'b1, 32'h4000_0000, 32'h0,
              32'h0000_0033, 32'h0000_0066, 4'b0000, 32'h0000_0066};
    vt[5] = '{1'b1, 1'b0, 32'h5000_0000, 32'h0,
              32'hAAAA_0000, 32'h0000_0066, 4'b1000, 32'hAAAA_0000};
    vt[6] = '{1'b1, 1'b1, 32'h3FFF_FFFC, 32'h0BAD_F00D,
              32'hAAAA_0000, 32'h0000_0066, 4'b0100, 32'hAAAA_0000};

    reset = 1; idle(); dm_rdata = 0; pr_rdata = 0;
    tick(); tick();
    reset = 0;

    // reset asserted in the middle of an m1 burst
    m1_req = 1; m1_we = 1; m1_lock = 1;
    m1_addr = 32'h0000_0010; m1_wdata = 32'h1;
    tick(); tick(); tick();
    m0_req = 1; m0_we = 1; m0_addr = 32'h20;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_gnt", i), {31'b0, m1_gnt}, 0);
      chk($sformatf("rst%0d_stall", i), {31'b0, m0_stall}, 0);
      chk($sformatf("rst%0d_strb", i), {28'b0, strb}, 0);
      tick();
    end
    reset = 0;
    m1_req = 0; m1_lock = 0;
    m0_we = 0; m0_addr = 32'h30;
    @(negedge clk);
    chk("post_rst_stall", {31'b0, m0_stall}, 0);
    chk("post_rst_strb", {28'b0, strb}, 4'b1000);
    tick();
    idle(); tick();

    // decode table, m0 owns the bus
    for (int i = 0; i < 7; i++) begin
      m0_req = vt[i].req; m0_we = vt[i].we;
      m0_addr = vt[i].addr; m0_wdata = vt[i].wdata;
      dm_rdata = vt[i].dmr; pr_rdata = vt[i].prr;
      @(negedge clk);
      chk($sformatf("v%0d_strb", i), {28'b0, strb}, {28'b0, vt[i].e_strb});
      chk($sformatf("v%0d_rdata", i), m0_rdata, vt[i].e_rdata);
      chk($sformatf("v%0d_praddr", i), pr_addr, vt[i].addr);
      chk($sformatf("v%0d_dmwd", i), dm_wdata, vt[i].wdata);
      chk($sformatf("v%0d_stall", i), {31'b0, m0_stall}, 0);
      tick();
    end
    idle(); tick();

    // m1 single write with m0 idle
    m1_req = 1; m1_we = 1;
    m1_addr = 32'h0000_0010; m1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("m1w_gnt0", {31'b0, m1_gnt}, 0);
    tick();
    @(negedge clk);
    chk("m1w_gnt1", {31'b0, m1_gnt}, 1);
    chk("m1w_strb", {28'b0, strb}, 4'b0100);
    chk("m1w_wdata", dm_wdata, 32'hDEAD_BEEF);
    chk("m1w_addr", dm_addr, 32'h10);
    tick();
    idle(); tick();

    // starvation: continuous m0 traffic
    m0_req = 1; m0_addr = 32'h100;
    m1_req = 1; m1_addr = 32'h4000_0000;
    pr_rdata = 32'h77; dm_rdata = 32'h11;
    gcyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (m1_gnt) begin
        gcyc = c;
        break;
      end
      tick();
    end
    chk("starve_cycle", gcyc, 9);
    chk("starve_stall", {31'b0, m0_stall}, 1);
    chk("starve_rvalid", {31'b0, m1_rvalid}, 1);
    chk("starve_m1rd", m1_rdata, 32'h77);
    chk("starve_m0rd", m0_rdata, 0);
    tick();
    m1_req = 0;
    @(negedge clk);
    chk("starve_m0_back", {27'b0, m0_stall, strb}, 5'b01000);
    tick();
    idle(); tick();

    // locked 20-beat burst into the peripheral window
    m1_req = 1; m1_we = 1; m1_lock = 1;
    m1_addr = 32'h4000_0000;
    ea = 32'h4000_0000;
    run1 = 0; gap = 0; beats = 0; phase = 0; bad = 0;
    for (int c = 0; c < 40 && beats < 20; c++) begin
      @(negedge clk);
      g = m1_gnt;
      if (g) begin
        beats++;
        if (pr_wr !== 1'b1 || dm_wr !== 1'b0 || pr_addr !== ea)
          bad++;
        if (phase == 0) phase = 1;
        if (phase == 1) run1++;
        if (phase == 2) phase = 3;
      end else if (phase == 1) begin
        phase = 2;
        gap = 1;
      end else if (phase == 2) begin
        gap++;
      end
      tick();
      if (g) begin
        m1_addr = m1_addr + 4;
        ea = ea + 4;
      end
    end
    chk("burst_beats", beats, 20);
    chk("burst_run1", run1, 16);
    chk("burst_gap", gap, 1);
    chk("burst_bad", bad, 0);
    m1_req = 0;
    @(negedge clk);
    chk("burst_drop_gnt", {31'b0, m1_gnt}, 0);
    chk("burst_drop_strb", {28'b0, strb}, 0);
    tick();
    idle(); tick();

    // m0 store stalled behind an m1 burst
    st = 0;
    m1_req = 1; m1_we = 1; m1_lock = 1;
    m1_addr = 32'h80; m1_wdata = 32'h5;
    @(negedge clk);
    tick();
    m0_req = 1; m0_we = 1;
    m0_addr = 32'h44; m0_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("st_b_stall", {31'b0, m0_stall}, 1);
    chk("st_b_addr", dm_addr, 32'h80);
    if (dm_wr && dm_addr == 32'h44 && dm_wdata == 32'h1234_5678) st++;
    tick();
    m1_lock = 0;
    @(negedge clk);
    chk("st_c_stall", {31'b0, m0_stall}, 1);
    chk("st_c_gnt", {31'b0, m1_gnt}, 1);
    if (dm_wr && dm_addr == 32'h44 && dm_wdata == 32'h1234_5678) st++;
    tick();
    m1_req = 0;
    @(negedge clk);
    chk("st_d_stall", {31'b0, m0_stall}, 0);
    chk("st_d_strb", {28'b0, strb}, 4'b0100);
    if (dm_wr && dm_addr == 32'h44 && dm_wdata == 32'h1234_5678) st++;
    tick();
    m0_req = 0; m0_we = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (dm_wr && dm_addr == 32'h44 && dm_wdata == 32'h1234_5678) st++;
      tick();
    end
    chk("st_once", st, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
